// File: rtl/rv32_ifu_pkg.sv
// Shared widths, reset defaults and the buffered-instruction payload for the RV32 fetch unit.
package rv32_ifu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int unsigned     DEPTH_DEF    = 2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic              fault;
    } inst_entry_t;

    // Sequential fetch step; wraps naturally at 32 bits.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module rv32_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/rv32_ifu.sv
// RV32 instruction fetch unit: credit-limited in-order imem reads, buffered for decode, flushed on redirect.
module rv32_ifu
    import rv32_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     DEPTH    = DEPTH_DEF
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_redirect_valid,
    input  logic [XLEN-1:0]   I_redirect_pc,
    output logic              O_imem_req_valid,
    input  logic              I_imem_req_ready,
    output logic [XLEN-1:0]   O_imem_req_addr,
    input  logic              I_imem_rsp_valid,
    input  logic [INST_W-1:0] I_imem_rsp_data,
    input  logic              I_imem_rsp_err,
    output logic              O_inst_valid,
    input  logic              I_inst_ready,
    output logic [INST_W-1:0] O_inst,
    output logic [XLEN-1:0]   O_inst_pc,
    output logic              O_inst_fault
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = $bits(inst_entry_t);

    logic            run_q, run_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            pend_q, pend_d;
    logic            stale_q, stale_d;
    logic [XLEN-1:0] stale_addr_q, stale_addr_d;

    logic [CW-1:0]   aq_count;
    logic            aq_empty;
    logic [XLEN-1:0] rsp_addr;
    logic [CW-1:0]   oq_count;
    logic            oq_empty;
    inst_entry_t     oq_head;
    inst_entry_t     oq_in;

    logic            credit;
    logic            fire;
    logic            hold;
    logic            keep;
    logic            oq_pop;
    logic [CW-1:0]   out_after;
    logic [XLEN-1:0] redirect_pc;

    // Address queue depth doubles as the outstanding-request count.
    assign credit           = (SW'(aq_count) + SW'(oq_count)) < SW'(DEPTH);
    assign O_imem_req_valid = run_q && (pend_q || credit);
    assign O_imem_req_addr  = stale_q ? stale_addr_q : fetch_pc_q;
    assign fire             = O_imem_req_valid && I_imem_req_ready;
    assign hold             = O_imem_req_valid && !I_imem_req_ready;
    assign keep             = I_imem_rsp_valid && (drop_q == '0) && !I_redirect_valid;
    assign oq_pop           = !oq_empty && I_inst_ready;
    assign out_after        = aq_count + CW'(fire) - CW'(I_imem_rsp_valid);
    assign redirect_pc      = I_redirect_pc & ~XLEN'(3);

    assign oq_in = '{inst: I_imem_rsp_data, pc: rsp_addr, fault: I_imem_rsp_err};

    assign O_inst_valid = !oq_empty;
    assign O_inst       = oq_head.inst;
    assign O_inst_pc    = oq_head.pc;
    assign O_inst_fault = oq_head.fault;

    rv32_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .flush     (1'b0),
        .push      (fire),
        .push_data (O_imem_req_addr),
        .pop       (I_imem_rsp_valid),
        .pop_data  (rsp_addr),
        .empty     (aq_empty),
        .count     (aq_count)
    );

    rv32_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_out_q (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .flush     (I_redirect_valid),
        .push      (keep),
        .push_data (oq_in),
        .pop       (oq_pop),
        .pop_data  (oq_head),
        .empty     (oq_empty),
        .count     (oq_count)
    );

    // A request held across a redirect keeps its old address and is counted as a drop.
    always_comb begin
        run_d        = 1'b1;
        fetch_pc_d   = fetch_pc_q;
        drop_d       = drop_q;
        pend_d       = hold;
        stale_d      = stale_q && hold;
        stale_addr_d = stale_addr_q;
        if (fire && !stale_q) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
        end
        if (I_imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (I_redirect_valid) begin
            fetch_pc_d   = redirect_pc;
            drop_d       = out_after + CW'(hold);
            stale_d      = hold;
            stale_addr_d = O_imem_req_addr;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            run_q        <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            drop_q       <= '0;
            pend_q       <= 1'b0;
            stale_q      <= 1'b0;
            stale_addr_q <= '0;
        end else begin
            run_q        <= run_d;
            fetch_pc_q   <= fetch_pc_d;
            drop_q       <= drop_d;
            pend_q       <= pend_d;
            stale_q      <= stale_d;
            stale_addr_q <= stale_addr_d;
        end
    end

    a_rsp_has_req: assert property (@(posedge I_clk) disable iff (!I_rst_n)
        I_imem_rsp_valid |-> !aq_empty);

endmodule

// File: tb/tb_rv32_ifu.sv
// Directed bench for rv32_ifu: per-cycle vector table plus redirect, stall and reset sequences.
module tb_rv32_ifu;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    rv32_ifu dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .I_redirect_valid (redirect_valid),
        .I_redirect_pc    (redirect_pc),
        .O_imem_req_valid (req_valid),
        .I_imem_req_ready (req_ready),
        .O_imem_req_addr  (req_addr),
        .I_imem_rsp_valid (rsp_valid),
        .I_imem_rsp_data  (rsp_data),
        .I_imem_rsp_err   (rsp_err),
        .O_inst_valid     (inst_valid),
        .I_inst_ready     (inst_ready),
        .O_inst           (inst),
        .O_inst_pc        (inst_pc),
        .O_inst_fault     (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

    typedef struct {
        logic        ir;
        logic        rr;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
        logic        flt;
    } vec_t;

    int          errors;
    int          checks;
    logic [31:0] mq [$];
    logic        mem_hold;

    logic        s_rv, s_fire, s_iv, s_flt;
    logic [31:0] s_ra, s_inst, s_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance the in-order memory model.
    task automatic step();
        logic [31:0] a;
        @(negedge clk);
        s_rv   = req_valid;
        s_ra   = req_addr;
        s_fire = req_valid && req_ready;
        s_iv   = inst_valid;
        s_inst = inst;
        s_pc   = inst_pc;
        s_flt  = inst_fault;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_err   = 1'b0;
        end else begin
            if (s_fire) mq.push_back(s_ra);
            if (!mem_hold && mq.size() > 0) begin
                a         = mq.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = mem_data(a);
                rsp_err   = (a == ERR_ADDR);
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
                rsp_err   = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(s_rv), 32'd0);
        chk({tag, "_inst_valid"}, 32'(s_iv), 32'd0);
        chk({tag, "_inst"}, s_inst, 32'd0);
        chk({tag, "_inst_pc"}, s_pc, 32'd0);
        chk({tag, "_inst_fault"}, 32'(s_flt), 32'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_err        = 1'b0;
        mq.delete();
        step();
        check_reset_outputs("rst");
        step();
        rst_n = 1'b1;
    endtask

    // Scan for the first post-redirect request and the first delivered instruction.
    task automatic expect_target(input string tag, input logic [31:0] tgt);
        logic found_req;
        logic found_inst;
        found_req  = 1'b0;
        found_inst = 1'b0;
        for (int k = 0; k < 20 && !(found_req && found_inst); k++) begin
            step();
            if (!found_req && s_fire) begin
                chk({tag, "_first_req_addr"}, s_ra, tgt);
                found_req = 1'b1;
            end
            if (!found_inst && s_iv) begin
                chk({tag, "_first_inst_pc"}, s_pc, tgt);
                chk({tag, "_first_inst"}, s_inst, mem_data(tgt));
                found_inst = 1'b1;
            end
        end
        chk({tag, "_req_seen"}, 32'(found_req), 32'd1);
        chk({tag, "_inst_seen"}, 32'(found_inst), 32'd1);
    endtask

    vec_t vecs [17];

    initial begin
        errors         = 0;
        checks         = 0;
        mem_hold       = 1'b0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b1;
        inst_ready     = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_err        = 1'b0;

        // Cycle-by-cycle: decode stalls 10 cycles, then drains; 0x80000008 returns a fault.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0,         1'b0};
        for (int i = 3; i <= 10; i++)
            vecs[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b0, 32'h0,         1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0008, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b0, 32'h0,         1'b0};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            inst_ready = vecs[i].ir;
            req_ready  = vecs[i].rr;
            step();
            chk($sformatf("v%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].rv));
            if (vecs[i].rv) chk($sformatf("v%0d_req_addr", i), s_ra, vecs[i].ra);
            chk($sformatf("v%0d_inst_valid", i), 32'(s_iv), 32'(vecs[i].iv));
            if (vecs[i].iv) begin
                chk($sformatf("v%0d_inst_pc", i), s_pc, vecs[i].ipc);
                chk($sformatf("v%0d_inst", i), s_inst, mem_data(vecs[i].ipc));
                chk($sformatf("v%0d_fault", i), 32'(s_flt), 32'(vecs[i].flt));
            end
        end

        // Redirect with two requests in flight: both responses discarded.
        do_reset();
        mem_hold   = 1'b1;
        inst_ready = 1'b1;
        req_ready  = 1'b1;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        chk("b_full_credit_req_valid", 32'(s_rv), 32'd0);
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        step();
        chk("b_post_redirect_inst_valid", 32'(s_iv), 32'd0);
        expect_target("b", 32'h8000_0100);

        // Request stalled by imem across a redirect: old address held, then dropped.
        do_reset();
        inst_ready = 1'b1;
        req_ready  = 1'b0;
        step();
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h8000_0100;
            end
            step();
            redirect_valid = 1'b0;
            chk($sformatf("c%0d_held_valid", c), 32'(s_rv), 32'd1);
            chk($sformatf("c%0d_held_addr", c), s_ra, 32'h8000_0000);
        end
        req_ready = 1'b1;
        step();
        chk("c6_stale_fire_addr", s_ra, 32'h8000_0000);
        chk("c6_stale_fire", 32'(s_fire), 32'd1);
        expect_target("c", 32'h8000_0100);

        // Reset asserted while the output buffer is full.
        do_reset();
        inst_ready = 1'b0;
        req_ready  = 1'b1;
        repeat (12) step();
        chk("d_full_inst_valid", 32'(s_iv), 32'd1);
        chk("d_full_req_valid", 32'(s_rv), 32'd0);
        rst_n     = 1'b0;
        rsp_valid = 1'b0;
        mq.delete();
        step();
        check_reset_outputs("d_midrst");
        step();
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        step();
        step();
        chk("d_restart_req_valid", 32'(s_rv), 32'd1);
        chk("d_restart_req_addr", s_ra, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
